// File: rtl/iob_double2ptfloat_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | iob_double2ptfloat_pkg                                             |
// | IEEE-754 double field layout, FSM encoding and pt-float widths.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package iob_double2ptfloat_pkg;

    localparam int FP_DP_DATA_W = 64;
    localparam int FP_DP_EXP_W  = 11;
    localparam int FP_DP_FRAC_W = 52;
    localparam int FP_DP_MAG_W  = FP_DP_FRAC_W + 1;
    localparam int FP_DP_BIAS   = 1023;
    localparam logic [FP_DP_EXP_W-1:0] FP_DP_EXP_SPECIAL = 11'h7FF;

    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] S_CLASS = 3'd1;
    localparam logic [STATE_W-1:0] S_NORM  = 3'd2;
    localparam logic [STATE_W-1:0] S_ROUND = 3'd3;
    localparam logic [STATE_W-1:0] S_PACK  = 3'd4;

    function automatic int exp_max_w(input int ew_w);
        return 2 ** (ew_w - 1);
    endfunction

    function automatic int man_max_w(input int data_w, input int ew_w);
        return data_w - ew_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/iob_rne_round.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | iob_rne_round                                                      |
// | Round-to-nearest-even of a magnitude to its top KEEP_W bits.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module iob_rne_round #(
    parameter int IN_W   = 53,
    parameter int KEEP_W = 27
) (
    input  logic [IN_W-1:0]   mag,
    output logic [KEEP_W-1:0] rounded,
    output logic              carry
);

    localparam int DROP_W = IN_W - KEEP_W;

    logic [KEEP_W-1:0] kept;
    logic [DROP_W-1:0] dropped;
    logic              guard;
    logic              sticky;
    logic              round_up;

    assign kept     = mag[IN_W-1 -: KEEP_W];
    assign dropped  = mag[DROP_W-1:0];
    assign guard    = dropped[DROP_W-1];
    assign sticky   = |(dropped & ~(DROP_W'(1) << (DROP_W - 1)));
    assign round_up = guard & (sticky | kept[0]);

    assign {carry, rounded} = {1'b0, kept} + (KEEP_W + 1)'(round_up);

endmodule
`default_nettype wire

// File: rtl/iob_double2ptfloat.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | iob_double2ptfloat                                                 |
// | Sequential IEEE-754 double to pt-float converter (start/done).     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module iob_double2ptfloat
    import iob_double2ptfloat_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int EW_W   = 4,
    localparam int EXP_MAX_W = exp_max_w(EW_W),
    localparam int MAN_MAX_W = man_max_w(DATA_W, EW_W)
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    cke_i,
    input  logic                    start_i,
    input  logic [FP_DP_DATA_W-1:0] fp_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [EXP_MAX_W-1:0]    exp_o,
    output logic [MAN_MAX_W-1:0]    man_o,
    output logic                    ovf_o,
    output logic                    unf_o,
    output logic                    nan_o
);

    localparam int KEEP_W = MAN_MAX_W - 1;
    // Wide enough for every double exponent plus round/renormalise steps.
    localparam int E_W    = (EXP_MAX_W + 2 > 13) ? EXP_MAX_W + 2 : 13;
    localparam logic signed [E_W-1:0] EXP_MAX = E_W'((2 ** (EXP_MAX_W - 1)) - 1);
    localparam logic signed [E_W-1:0] EXP_MIN = E_W'(-(2 ** (EXP_MAX_W - 1)));
    localparam logic signed [E_W-1:0] SUB_EXP = E_W'(2 - FP_DP_BIAS);
    localparam logic [KEEP_W-1:0]    KEEP_HALF   = {1'b1, {(KEEP_W-1){1'b0}}};
    localparam logic [MAN_MAX_W-1:0] MAN_POS_SAT = {1'b0, {KEEP_W{1'b1}}};
    localparam logic [MAN_MAX_W-1:0] MAN_NEG_ONE = {1'b1, {KEEP_W{1'b0}}};

    logic [STATE_W-1:0]      state;
    logic [FP_DP_DATA_W-1:0] fp;
    logic                    sign;
    logic                    is_zero;
    logic                    is_inf;
    logic                    is_nan;
    logic [FP_DP_MAG_W-1:0]  mag;
    logic signed [E_W-1:0]   e;

    logic [FP_DP_EXP_W-1:0]  fp_exp;
    logic [FP_DP_FRAC_W-1:0] fp_frac;
    logic [KEEP_W-1:0]       rnd_man;
    logic                    rnd_carry;
    logic [KEEP_W-1:0]       kept;
    logic signed [E_W-1:0]   e_adj;
    logic [EXP_MAX_W-1:0]    pk_exp;
    logic [MAN_MAX_W-1:0]    pk_man;
    logic                    pk_ovf;
    logic                    pk_unf;
    logic                    pk_nan;

    assign fp_exp  = fp[FP_DP_DATA_W-2 -: FP_DP_EXP_W];
    assign fp_frac = fp[FP_DP_FRAC_W-1:0];
    assign kept    = mag[FP_DP_MAG_W-1 -: KEEP_W];
    assign busy_o  = (state != S_IDLE);

    iob_rne_round #(
        .IN_W   (FP_DP_MAG_W),
        .KEEP_W (KEEP_W)
    ) u_rne_round (
        .mag     (mag),
        .rounded (rnd_man),
        .carry   (rnd_carry)
    );

    // -0.5 is not a normalised two's-complement mantissa; it becomes -1.0 one exponent lower.
    always_comb begin
        pk_ovf = 1'b0;
        pk_unf = 1'b0;
        pk_nan = 1'b0;
        e_adj  = e;
        pk_man = {1'b0, kept};
        if (sign) begin
            pk_man = -{1'b0, kept};
            if (kept == KEEP_HALF) begin
                pk_man = MAN_NEG_ONE;
                e_adj  = e - E_W'(1);
            end
        end
        pk_exp = e_adj[EXP_MAX_W-1:0];
        if (is_nan) begin
            pk_exp = EXP_MAX[EXP_MAX_W-1:0];
            pk_man = '0;
            pk_nan = 1'b1;
        end else if (is_inf || (!is_zero && (e_adj > EXP_MAX))) begin
            pk_exp = EXP_MAX[EXP_MAX_W-1:0];
            pk_man = sign ? MAN_NEG_ONE : MAN_POS_SAT;
            pk_ovf = 1'b1;
        end else if (is_zero || (e_adj < EXP_MIN)) begin
            pk_exp = EXP_MIN[EXP_MAX_W-1:0];
            pk_man = '0;
            pk_unf = ~is_zero;
        end
    end

    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            if (!rst_n_i) begin
                state   <= S_IDLE;
                fp      <= '0;
                sign    <= 1'b0;
                is_zero <= 1'b0;
                is_inf  <= 1'b0;
                is_nan  <= 1'b0;
                mag     <= '0;
                e       <= '0;
                done_o  <= 1'b0;
                exp_o   <= '0;
                man_o   <= '0;
                ovf_o   <= 1'b0;
                unf_o   <= 1'b0;
                nan_o   <= 1'b0;
            end else begin
                done_o <= 1'b0;
                case (state)
                    S_IDLE: begin
                        if (start_i) begin
                            fp    <= fp_i;
                            state <= S_CLASS;
                        end
                    end
                    S_CLASS: begin
                        sign    <= fp[FP_DP_DATA_W-1];
                        is_zero <= 1'b0;
                        is_inf  <= 1'b0;
                        is_nan  <= 1'b0;
                        if (fp_exp == '0) begin
                            if (fp_frac == '0) begin
                                is_zero <= 1'b1;
                                state   <= S_PACK;
                            end else begin
                                mag   <= {1'b0, fp_frac};
                                e     <= SUB_EXP;
                                state <= S_NORM;
                            end
                        end else if (fp_exp == FP_DP_EXP_SPECIAL) begin
                            is_nan <= |fp_frac;
                            is_inf <= ~|fp_frac;
                            state  <= S_PACK;
                        end else begin
                            mag   <= {1'b1, fp_frac};
                            e     <= $signed({{(E_W-FP_DP_EXP_W){1'b0}}, fp_exp}) - E_W'(FP_DP_BIAS - 1);
                            state <= S_ROUND;
                        end
                    end
                    S_NORM: begin
                        mag <= mag << 1;
                        e   <= e - E_W'(1);
                        if (mag[FP_DP_MAG_W-2]) begin
                            state <= S_ROUND;
                        end
                    end
                    S_ROUND: begin
                        if (rnd_carry) begin
                            mag <= {1'b1, {FP_DP_FRAC_W{1'b0}}};
                            e   <= e + E_W'(1);
                        end else begin
                            mag <= {rnd_man, {(FP_DP_MAG_W-KEEP_W){1'b0}}};
                        end
                        state <= S_PACK;
                    end
                    S_PACK: begin
                        exp_o  <= pk_exp;
                        man_o  <= pk_man;
                        ovf_o  <= pk_ovf;
                        unf_o  <= pk_unf;
                        nan_o  <= pk_nan;
                        done_o <= 1'b1;
                        state  <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iob_double2ptfloat.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | tb_iob_double2ptfloat                                              |
// | Bench for the double to pt-float converter (DATA_W=32, EW_W=4).    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_iob_double2ptfloat;

    localparam int MW   = 28;
    localparam int XW   = 8;
    localparam int EMAX = 127;
    localparam int EMIN = -128;

    typedef struct {
        logic [XW-1:0] ex;
        logic [MW-1:0] man;
        bit            ovf;
        bit            unf;
        bit            nan;
        int            lat;
        int            st;
        int            dn;
    } res_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          cke   = 1'b1;
    logic          start = 1'b0;
    logic [63:0]   fp    = '0;
    logic          busy;
    logic          done;
    logic [XW-1:0] exp_v;
    logic [MW-1:0] man;
    logic          ovf;
    logic          unf;
    logic          nan;

    res_t q[$];
    res_t last;
    res_t zero_res = '{ex: '0, man: '0, ovf: 0, unf: 0, nan: 0, lat: 0, st: 0, dn: 0};
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    logic [63:0] vecs [18] = '{
        64'h3FF0000000000000, 64'hBFF0000000000000, 64'h0000000000000000,
        64'h8000000000000000, 64'h3FF0000002000000, 64'h3FF0000006000000,
        64'h3FFFFFFFFFFFFFFF, 64'h47F0000000000000, 64'h7FF8000000000001,
        64'hFFF0000000000000, 64'h7FF0000000000000, 64'h0000000000000001,
        64'h0008000000000000, 64'h47D0000000000000, 64'hC7E0000000000000,
        64'h37E0000000000000, 64'h37D0000000000000, 64'h400921FB54442D18
    };

    always #5 clk = ~clk;

    iob_double2ptfloat #(
        .DATA_W (32),
        .EW_W   (4)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .cke_i   (cke),
        .start_i (start),
        .fp_i    (fp),
        .busy_o  (busy),
        .done_o  (done),
        .exp_o   (exp_v),
        .man_o   (man),
        .ovf_o   (ovf),
        .unf_o   (unf),
        .nan_o   (nan)
    );

    // Exact value |x| = s * 2^q2, rounded to MW-1 magnitude bits with integer RNE.
    function automatic res_t model(input logic [63:0] x);
        res_t r;
        logic [10:0] bexp;
        logic [51:0] frac;
        longint unsigned s, n, rem, half;
        int q2, bl, e, sh;
        r = zero_res;
        r.lat = 2;
        bexp = x[62:52];
        frac = x[51:0];
        if (bexp == 11'h7FF) begin
            r.ex = XW'(EMAX);
            if (frac != 0) r.nan = 1;
            else begin
                r.ovf = 1;
                r.man = x[63] ? {1'b1, {(MW-1){1'b0}}} : {1'b0, {(MW-1){1'b1}}};
            end
            return r;
        end
        if (bexp == 0 && frac == 0) begin
            r.ex = XW'(EMIN);
            return r;
        end
        if (bexp == 0) begin
            s  = {12'd0, frac};
            q2 = -1074;
        end else begin
            s  = {11'd0, 1'b1, frac};
            q2 = int'(bexp) - 1075;
        end
        bl = 0;
        for (int i = 0; i < 64; i++) if (s[i]) bl = i + 1;
        r.lat = (bexp == 0) ? 3 + 53 - bl : 3;
        e  = q2 + bl;
        sh = bl - (MW - 1);
        if (sh <= 0) n = s << (-sh);
        else begin
            n    = s >> sh;
            rem  = s - (n << sh);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && n[0])) n++;
        end
        if (n == (64'd1 << (MW - 1))) begin
            n = 64'd1 << (MW - 2);
            e++;
        end
        if (x[63] && n == (64'd1 << (MW - 2))) begin
            n = 64'd1 << (MW - 1);
            e--;
        end
        if (e > EMAX) begin
            r.ovf = 1;
            r.ex  = XW'(EMAX);
            r.man = x[63] ? {1'b1, {(MW-1){1'b0}}} : {1'b0, {(MW-1){1'b1}}};
        end else if (e < EMIN) begin
            r.unf = 1;
            r.ex  = XW'(EMIN);
        end else begin
            r.ex  = XW'(e);
            r.man = x[63] ? MW'(-n) : MW'(n);
        end
        return r;
    endfunction

    task automatic pin(input string name, input logic [63:0] x, input logic [XW-1:0] ex,
                       input logic [MW-1:0] mn, input logic [2:0] flags, input int lat);
        res_t r;
        r = model(x);
        checks++;
        if (r.ex !== ex || r.man !== mn || {r.ovf, r.unf, r.nan} !== flags || r.lat != lat) begin
            errors++;
            $display("FAIL pin_%s: model exp=%h man=%h ovf/unf/nan=%b%b%b lat=%0d, required exp=%h man=%h flags=%b lat=%0d",
                     name, r.ex, r.man, r.ovf, r.unf, r.nan, r.lat, ex, mn, flags, lat);
        end
    endtask

    always @(posedge clk) begin : p_cmp
        res_t w;
        logic eb;
        cyc++;
        #1;
        eb = (q.size() > 0) && (cyc >= q[0].st) && (cyc < q[0].dn);
        checks++;
        if (busy !== eb) begin
            errors++;
            $display("FAIL busy cyc=%0d: got %b, required %b", cyc, busy, eb);
        end
        if (done === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done cyc=%0d: got done=1, required 0", cyc);
            end else begin
                w = q.pop_front();
                if (cyc != w.dn || exp_v !== w.ex || man !== w.man ||
                    {ovf, unf, nan} !== {w.ovf, w.unf, w.nan}) begin
                    errors++;
                    $display("FAIL result cyc=%0d: got exp=%h man=%h flags=%b%b%b, required cyc=%0d exp=%h man=%h flags=%b%b%b",
                             cyc, exp_v, man, ovf, unf, nan, w.dn, w.ex, w.man, w.ovf, w.unf, w.nan);
                end
                last = w;
            end
        end else begin
            if (q.size() > 0 && cyc >= q[0].dn) begin
                checks++;
                errors++;
                $display("FAIL missing_done cyc=%0d: got done=0, required 1", cyc);
                void'(q.pop_front());
            end
            checks++;
            if (exp_v !== last.ex || man !== last.man || {ovf, unf, nan} !== {last.ovf, last.unf, last.nan}) begin
                errors++;
                $display("FAIL held cyc=%0d: got exp=%h man=%h flags=%b%b%b, required exp=%h man=%h flags=%b%b%b",
                         cyc, exp_v, man, ovf, unf, nan, last.ex, last.man, last.ovf, last.unf, last.nan);
            end
        end
    end

    // Called at a negedge; start is seen at the next posedge.
    task automatic convert(input logic [63:0] x, input int extra);
        res_t r;
        r = model(x);
        r.st = cyc + 1;
        r.dn = cyc + 1 + r.lat + extra;
        q.push_back(r);
        fp = x;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic poke(input logic [63:0] x);
        fp = x;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d pending results, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        last = zero_res;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        pin("one",      64'h3FF0000000000000, 8'h01, 28'h4000000, 3'b000, 3);
        pin("neg_one",  64'hBFF0000000000000, 8'h00, 28'h8000000, 3'b000, 3);
        pin("zero",     64'h8000000000000000, 8'h80, 28'h0000000, 3'b000, 2);
        pin("tie_even", 64'h3FF0000002000000, 8'h01, 28'h4000000, 3'b000, 3);
        pin("tie_up",   64'h3FF0000006000000, 8'h01, 28'h4000002, 3'b000, 3);
        pin("carry",    64'h3FFFFFFFFFFFFFFF, 8'h02, 28'h4000000, 3'b000, 3);
        pin("ovf",      64'h47F0000000000000, 8'h7F, 28'h7FFFFFF, 3'b100, 3);
        pin("nan",      64'h7FF8000000000001, 8'h7F, 28'h0000000, 3'b001, 2);
        pin("neg_inf",  64'hFFF0000000000000, 8'h7F, 28'h8000000, 3'b100, 2);
        pin("min_sub",  64'h0000000000000001, 8'h80, 28'h0000000, 3'b010, 55);
        pin("sub_bit51",64'h0008000000000000, 8'h80, 28'h0000000, 3'b010, 4);
        pin("neg_max",  64'hC7E0000000000000, 8'h7F, 28'h8000000, 3'b000, 3);
        pin("min_norm", 64'h37E0000000000000, 8'h80, 28'h4000000, 3'b000, 3);
        pin("neg_three",64'hC008000000000000, 8'h02, 28'hA000000, 3'b000, 3);

        foreach (vecs[i]) begin
            convert(vecs[i], 0);
            wait_idle();
        end

        // back-to-back: second start lands in the done cycle of the first
        convert(64'h3FF8000000000000, 0);
        wait_done();
        convert(64'hC008000000000000, 0);
        wait_done();
        convert(64'h0000000000000000, 0);
        wait_idle();

        convert(64'h0000000000000001, 0);
        poke(64'h3FF0000000000000);
        poke(64'hFFF0000000000000);
        wait_idle();

        convert(64'h3FF8000000000000, 5);
        @(negedge clk);
        cke = 1'b0;
        repeat (5) @(negedge clk);
        cke = 1'b1;
        wait_idle();

        convert(64'h0000000000000001, 0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        last = zero_res;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        convert(64'hBFF0000000000000, 0);
        wait_idle();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

endmodule
`default_nettype wire
